mbx_quad_fill: RTL and testbench



---
 rtl/mbx_quad_fill.sv | 169 ++++++++++++++++
 tb/tb_mbx_quad_fill.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbx_quad_fill.sv
// Quadword fill controller for the MB0..MB3 memory buffer: steers arriving
// memory words into their MB word, tracks validity and drains in wrap order.
module mbx_quad_fill #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned TO_W        = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] start_word,
    input  logic       mem_word_valid,
    input  logic [1:0] mem_word_num,
    output logic [3:0] mb_hold,
    output logic [2:0] mb_in_sel,
    output logic [1:0] mb_sel_en,
    output logic       mb_sel_hold,
    output logic       nxm_any,
    output logic       out_valid,
    output logic [1:0] out_word,
    input  logic       out_ack,
    output logic       busy,
    output logic       done,
    output logic       dup_err
);

    localparam int unsigned NWORDS = 4;
    localparam logic [2:0]  IN_SEL_MEM = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_NXM  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [NWORDS-1:0] r_valid;
    logic [1:0]        r_ptr;
    logic [1:0]        r_ack_cnt;
    logic [TO_W-1:0]   r_to;
    logic              r_settled;
    logic              r_nxm;
    logic              r_dup;
    logic              r_done;

    logic w_start;
    logic w_out_valid;
    logic w_acc;
    logic w_timeout;

    assign w_start     = start && (r_state != S_BUSY);
    assign w_out_valid = (r_state == S_BUSY) && r_valid[r_ptr] && r_settled;
    assign w_acc       = w_out_valid && out_ack;
    assign w_timeout   = (r_state == S_BUSY) && (r_valid != 4'hF) && !mem_word_valid
                         && (r_to == TO_W'(MEM_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_NXM: begin
                if (start) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_acc && (r_ack_cnt == 2'd3)) begin
                    w_next = S_IDLE;
                end else if (w_timeout) begin
                    w_next = S_NXM;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs; held inactive while reset is asserted so no MB word loads at the reset edge
    always_comb begin
        mb_hold     = 4'hF;
        mb_in_sel   = 3'b000;
        mb_sel_en   = 2'b00;
        mb_sel_hold = 1'b1;
        out_valid   = 1'b0;
        busy        = (r_state == S_BUSY);
        out_word    = r_ptr;
        nxm_any     = r_nxm;
        dup_err     = r_dup;
        done        = r_done;
        if (rst_n) begin
            case (r_state)
                S_IDLE, S_NXM: begin
                    if (start) begin
                        mb_sel_hold = 1'b0;
                        mb_sel_en   = start_word;
                    end
                end
                S_BUSY: begin
                    mb_in_sel = IN_SEL_MEM;
                    out_valid = w_out_valid;
                    for (int n = 0; n < NWORDS; n++) begin
                        mb_hold[n] = !(mem_word_valid && (mem_word_num == 2'(n)));
                    end
                    if (w_acc) begin
                        mb_sel_hold = 1'b0;
                        mb_sel_en   = r_ptr + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fill tracking, drain pointer and timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_ptr     <= '0;
            r_ack_cnt <= '0;
            r_to      <= '0;
            r_settled <= 1'b1;
            r_nxm     <= 1'b0;
            r_dup     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_settled <= 1'b1;
            if (w_start) begin
                r_valid   <= '0;
                r_ack_cnt <= '0;
                r_to      <= '0;
                r_dup     <= 1'b0;
                r_nxm     <= 1'b0;
                r_ptr     <= start_word;
                r_settled <= 1'b0;
            end else if (r_state == S_BUSY) begin
                if (mem_word_valid) begin
                    if (r_valid[mem_word_num]) begin
                        r_dup <= 1'b1;
                    end
                    r_valid[mem_word_num] <= 1'b1;
                    r_to                  <= '0;
                end else if (r_valid != 4'hF) begin
                    r_to <= r_to + TO_W'(1);
                end
                if (w_acc) begin
                    r_ptr     <= r_ptr + 2'd1;
                    r_settled <= 1'b0;
                    r_ack_cnt <= r_ack_cnt + 2'd1;
                    if (r_ack_cnt == 2'd3) begin
                        r_done <= 1'b1;
                    end
                end
                if (w_timeout) begin
                    r_nxm <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbx_quad_fill.sv
// Self-checking bench for mbx_quad_fill: a small fill/drain model plus a
// queue of expected drain words popped on each accepted ack.
module tb_mbx_quad_fill;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] start_word;
    logic       mem_word_valid;
    logic [1:0] mem_word_num;
    logic [3:0] mb_hold;
    logic [2:0] mb_in_sel;
    logic [1:0] mb_sel_en;
    logic       mb_sel_hold;
    logic       nxm_any;
    logic       out_valid;
    logic [1:0] out_word;
    logic       out_ack;
    logic       busy;
    logic       done;
    logic       dup_err;

    int errors = 0;
    int checks = 0;
    logic [1:0] sb[$];

    always #5 clk = ~clk;

    mbx_quad_fill #(.MEM_TIMEOUT(64), .TO_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_word(start_word),
        .mem_word_valid(mem_word_valid), .mem_word_num(mem_word_num),
        .mb_hold(mb_hold), .mb_in_sel(mb_in_sel), .mb_sel_en(mb_sel_en),
        .mb_sel_hold(mb_sel_hold), .nxm_any(nxm_any), .out_valid(out_valid),
        .out_word(out_word), .out_ack(out_ack), .busy(busy), .done(done),
        .dup_err(dup_err)
    );

    // Inputs change just after the falling edge; outputs are sampled 1ns later
    task automatic drive(input logic st, input logic [1:0] sw, input logic mv,
                         input logic [1:0] mn, input logic ack);
        @(negedge clk);
        start = st; start_word = sw; mem_word_valid = mv; mem_word_num = mn; out_ack = ack;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; start_word = 2'd0;
        mem_word_valid = 1'b0; mem_word_num = 2'd0; out_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // One full fill: sched[c] is the word arriving in cycle c after start (-1 = none)
    task automatic run_fill(input logic [1:0] sw, input int sched[$], input logic exp_dup);
        logic [3:0] m_valid = 4'h0;
        logic [1:0] m_ptr = sw;
        logic [1:0] m_nxt;
        logic       m_set = 1'b0;
        logic       m_ov;
        logic       mv;
        logic [1:0] mn;
        logic [3:0] exp_hold;
        logic [1:0] exp_w;
        int         acks = 0;
        bit         fin = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) sb.push_back(2'(int'(sw) + i));
        drive(1'b1, sw, 1'b0, 2'd0, 1'b0);
        checks++;
        if (mb_sel_hold !== 1'b0 || mb_sel_en !== sw) begin
            errors++;
            $display("FAIL start_sel got hold=%b en=%0d exp hold=0 en=%0d", mb_sel_hold, mb_sel_en, sw);
        end
        for (int c = 0; c < 300 && !fin; c++) begin
            mv = (c < sched.size()) && (sched[c] >= 0);
            mn = mv ? 2'(sched[c]) : 2'd0;
            m_ov = m_valid[m_ptr] & m_set;
            exp_hold = mv ? ~(4'b0001 << mn) : 4'hF;
            drive(1'b0, 2'd0, mv, mn, m_ov);
            checks++;
            if (out_valid !== m_ov) begin
                errors++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b", c, out_valid, m_ov);
            end
            checks++;
            if (mb_hold !== exp_hold || mb_in_sel !== 3'b100 || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_outs cyc=%0d got hold=%b insel=%b busy=%b exp hold=%b insel=100 busy=1",
                         c, mb_hold, mb_in_sel, busy, exp_hold);
            end
            if (c == 0) begin
                checks++;
                if (nxm_any !== 1'b0) begin
                    errors++;
                    $display("FAIL nxm_clear got=%b exp=0", nxm_any);
                end
            end
            if (m_ov) begin
                exp_w = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
                m_nxt = m_ptr + 2'd1;
                checks++;
                if (out_word !== exp_w || mb_sel_hold !== 1'b0 || mb_sel_en !== m_nxt) begin
                    errors++;
                    $display("FAIL drain_word got word=%0d hold=%b en=%0d exp word=%0d hold=0 en=%0d",
                             out_word, mb_sel_hold, mb_sel_en, exp_w, m_nxt);
                end
            end
            if (mv) m_valid[mn] = 1'b1;
            if (m_ov) begin
                m_ptr = m_ptr + 2'd1;
                m_set = 1'b0;
                acks++;
                if (acks == 4) fin = 1'b1;
            end else begin
                m_set = 1'b1;
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL fill_timeout got acks=%0d exp acks=4", acks);
        end
        drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dup_err !== exp_dup) begin
            errors++;
            $display("FAIL completion got done=%b busy=%b dup=%b exp done=1 busy=0 dup=%b",
                     done, busy, dup_err, exp_dup);
        end
        drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mb_hold !== 4'hF || mb_sel_hold !== 1'b1 || mb_sel_en !== 2'd0 || mb_in_sel !== 3'b000 ||
            out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || nxm_any !== 1'b0 || dup_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals got hold=%b selh=%b sel=%0d insel=%b ov=%b busy=%b done=%b nxm=%b dup=%b exp 1111 1 0 000 0 0 0 0 0",
                     mb_hold, mb_sel_hold, mb_sel_en, mb_in_sel, out_valid, busy, done, nxm_any, dup_err);
        end
    endtask

    task automatic test_in_order();
        int s[$];
        s.push_back(2); s.push_back(3); s.push_back(0); s.push_back(1);
        run_fill(2'd2, s, 1'b0);
    endtask

    task automatic test_spaced();
        int s[$];
        int ord[4] = '{3, 1, 2, 0};
        for (int i = 0; i < 4; i++) begin
            s.push_back(ord[i]);
            if (i < 3) repeat (4) s.push_back(-1);
        end
        run_fill(2'd0, s, 1'b0);
    endtask

    task automatic test_back_to_back();
        int s[$];
        s.push_back(0); s.push_back(1); s.push_back(2); s.push_back(3);
        run_fill(2'd3, s, 1'b0);
        run_fill(2'd1, s, 1'b0);
    endtask

    task automatic test_nxm();
        int s[$];
        do_reset();
        drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
        for (int k = 1; k <= 65; k++) begin
            drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
            checks++;
            if (nxm_any !== (k == 65)) begin
                errors++;
                $display("FAIL nxm_timing k=%0d got=%b exp=%b", k, nxm_any, (k == 65));
            end
        end
        drive(1'b0, 2'd0, 1'b1, 2'd2, 1'b1);
        checks++;
        if (mb_hold !== 4'hF || busy !== 1'b0 || out_valid !== 1'b0 || mb_in_sel !== 3'b000) begin
            errors++;
            $display("FAIL nxm_outs got hold=%b busy=%b ov=%b insel=%b exp 1111 0 0 000",
                     mb_hold, busy, out_valid, mb_in_sel);
        end
        s.push_back(1); s.push_back(2); s.push_back(3); s.push_back(0);
        run_fill(2'd1, s, 1'b0);
    endtask

    task automatic test_dup();
        int s[$];
        s.push_back(1); s.push_back(0); s.push_back(1); s.push_back(2); s.push_back(3);
        run_fill(2'd0, s, 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        int acks = 0;
        do_reset();
        drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        for (int c = 0; c < 20 && acks < 2; c++) begin
            drive(1'b0, 2'd0, (c < 4), 2'(c), 1'b0);
            if (out_valid) begin
                out_ack = 1'b1;
                acks++;
            end
        end
        checks++;
        if (acks != 2) begin
            errors++;
            $display("FAIL pre_reset_acks got=%0d exp=2", acks);
        end
        @(negedge clk);
        rst_n = 1'b0; mem_word_valid = 1'b1; mem_word_num = 2'd3; out_ack = 1'b0;
        #1;
        checks++;
        if (mb_hold !== 4'hF) begin
            errors++;
            $display("FAIL reset_cycle_hold got=%b exp=1111", mb_hold);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_word_valid = 1'b0;
        #1;
        checks++;
        if (mb_hold !== 4'hF || mb_sel_hold !== 1'b1 || mb_sel_en !== 2'd0 || mb_in_sel !== 3'b000 ||
            out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || nxm_any !== 1'b0 || dup_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_vals got hold=%b selh=%b sel=%0d insel=%b ov=%b busy=%b done=%b nxm=%b dup=%b exp 1111 1 0 000 0 0 0 0 0",
                     mb_hold, mb_sel_hold, mb_sel_en, mb_in_sel, out_valid, busy, done, nxm_any, dup_err);
        end
        for (int n = 0; n < 4; n++) begin
            drive(1'b0, 2'd0, 1'b1, 2'(n), 1'b0);
            checks++;
            if (mb_hold !== 4'hF || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore n=%0d got hold=%b ov=%b exp 1111 0", n, mb_hold, out_valid);
            end
        end
    endtask

    task automatic test_stray_ack();
        do_reset();
        drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_word !== 2'd0 || mb_sel_hold !== 1'b1) begin
            errors++;
            $display("FAIL stray_ack got ov=%b word=%0d selh=%b exp 0 0 1", out_valid, out_word, mb_sel_hold);
        end
        drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 2'd0) begin
            errors++;
            $display("FAIL stray_next got ov=%b word=%0d exp 1 0", out_valid, out_word);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_spaced();
        test_back_to_back();
        test_nxm();
        test_dup();
        test_reset_mid_drain();
        test_stray_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
